// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 word constants, schedule FSM encoding, K table and small sigma functions
package sha256_pkg;
  localparam int WRD_SIZE = 32;
  localparam int NUM_ROUNDS = 64;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: combinational SHA-256 round constant lookup (addr -> K[addr])
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  addr,
  output logic [31:0] k
);
  assign k = K_TAB[addr];
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: expands a 512-bit block into W[0..63], one word per round handshake
// Ports: clk; reset_n sync active-low; i_start/i_msg_blk load a block in IDLE (W0 = [511:480]);
// o_valid/i_ready round handshake carrying o_w, o_k, o_round_idx; o_busy in RUN and DONE;
// o_done one-cycle pulse after W[63] is accepted.
// SHA256_MSG_SCHEDULE_K_ROM_EN: o_k comes from the internal K ROM; otherwise o_k is tied to 0.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int BLK_SIZE = 512
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_start,
  input  logic [BLK_SIZE-1:0] i_msg_blk,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [WRD_SIZE-1:0] o_w,
  output logic [WRD_SIZE-1:0] o_k,
  output logic [5:0]          o_round_idx,
  output logic                o_busy,
  output logic                o_done
);
  state_t state;
  logic [WRD_SIZE-1:0] win [16];
  logic [5:0] t;
  logic run;
  logic [WRD_SIZE-1:0] w_new;
  assign run = state == RUN;
  // window[0] is W[t]; the word 16 ahead needs W[t+14], W[t+9], W[t+1], W[t]
  assign w_new = s1(win[14]) + win[9] + s0(win[1]) + win[0];
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      t <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else
      case (state)
        IDLE:
          if (i_start) begin
            state <= RUN;
            t <= '0;
            for (int i = 0; i < 16; i++) win[i] <= i_msg_blk[BLK_SIZE-1-WRD_SIZE*i -: WRD_SIZE];
          end
        RUN:
          if (i_ready) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_new;
            t <= t + 6'd1;
            if (t == 6'(NUM_ROUNDS - 1)) state <= DONE;
          end
        default: state <= IDLE;
      endcase
  assign o_valid = run;
  assign o_w = run ? win[0] : '0;
  assign o_round_idx = run ? t : '0;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
`ifdef SHA256_MSG_SCHEDULE_K_ROM_EN
  logic [WRD_SIZE-1:0] k_rom;
  sha256_k_rom u_k_rom (
    .addr(t),
    .k   (k_rom)
  );
  assign o_k = run ? k_rom : '0;
`else
  assign o_k = '0;
`endif
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized self-checking bench against a plain-arithmetic SHA-256 schedule model
module tb_sha256_msg_schedule;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  logic clk = 0, reset_n = 0, i_start = 0, i_ready = 0;
  logic [511:0] i_msg_blk = '0;
  logic o_valid, o_busy, o_done;
  logic [31:0] o_w, o_k;
  logic [5:0] o_round_idx;
  int total = 0, bad = 0;
  logic [31:0] ref_w [64];
  always #5 clk = ~clk;
  sha256_msg_schedule dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_msg_blk(i_msg_blk), .i_ready(i_ready),
    .o_valid(o_valid), .o_w(o_w), .o_k(o_k), .o_round_idx(o_round_idx), .o_busy(o_busy), .o_done(o_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  task automatic build_ref(input logic [511:0] b);
    for (int i = 0; i < 16; i++) ref_w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      ref_w[i] = (rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10)) + ref_w[i-7]
               + (rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3)) + ref_w[i-16];
  endtask
  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction
  // mode 0: ready held high; 1: random stalls plus 10-cycle stalls at t=15 and t=63;
  // 2: i_start with another block at t=20; 3: reset at t=30
  task automatic run_block(input logic [511:0] blk, input int mode, input bit b2b);
    int t = 0, cyc = 0, held = 0;
    build_ref(blk);
    i_msg_blk = blk;
    i_start = 1;
    i_ready = 1;
    @(negedge clk);
    i_start = 0;
    i_msg_blk = rand_blk();
    check("latency", 32'(o_valid), 1);
    while (t < 64 && cyc < 4000) begin
      check("valid", 32'(o_valid), 1);
      check("busy", 32'(o_busy), 1);
      check("w", o_w, ref_w[t]);
      check("idx", 32'(o_round_idx), t);
`ifdef SHA256_MSG_SCHEDULE_K_ROM_EN
      if (t == 0) check("k0", o_k, 32'h428a2f98);
      if (t == 63) check("k63", o_k, 32'hc67178f2);
`else
      check("k_tied", o_k, 0);
`endif
      if (blk == ABC && t == 0) check("abc_w0", o_w, 32'h61626380);
      if (blk == ABC && t == 15) check("abc_w15", o_w, 32'h00000018);
      if (blk == ABC && t == 16) check("abc_w16", o_w, 32'h61626380);
      if (blk == ABC && t == 17) check("abc_w17", o_w, 32'h000f0000);
      if (mode == 3 && t == 30) begin
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_w", o_w, 0);
        check("rst_k", o_k, 0);
        check("rst_idx", 32'(o_round_idx), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        held = 0;
        repeat (80) begin
          @(negedge clk);
          if (o_done || o_valid) held = 1;
        end
        check("no_done_after_rst", held, 0);
        return;
      end
      i_start = (mode == 2 && t == 20);
      if (i_start) i_msg_blk = rand_blk();
      if (mode == 1) begin
        if ((t == 15 || t == 63) && held < 10) begin
          i_ready = 0;
          held++;
        end else i_ready = ($urandom_range(0, 3) != 0);
      end else i_ready = 1;
      @(negedge clk);
      cyc++;
      if (i_ready) begin
        t++;
        held = 0;
      end
    end
    i_start = 0;
    if (t < 64) check("timeout", t, 64);
    check("done", 32'(o_done), 1);
    check("done_valid", 32'(o_valid), 0);
    check("done_busy", 32'(o_busy), 1);
    if (mode == 0) check("done_lat", cyc, 64);
    if (b2b) begin
      i_start = 1;
      i_msg_blk = rand_blk();
    end
    @(negedge clk);
    check("done_once", 32'(o_done), 0);
    check("idle_valid", 32'(o_valid), 0);
    check("idle_busy", 32'(o_busy), 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(o_valid), 0);
    check("reset_w", o_w, 0);
    check("reset_k", o_k, 0);
    check("reset_idx", 32'(o_round_idx), 0);
    check("reset_busy", 32'(o_busy), 0);
    check("reset_done", 32'(o_done), 0);
    reset_n = 1;
    @(negedge clk);
    run_block(ABC, 0, 0);
    run_block(ABC, 1, 0);
    run_block(rand_blk(), 1, 0);
    run_block(rand_blk(), 2, 0);
    run_block(rand_blk(), 0, 1);
    run_block(rand_blk(), 0, 0);
    run_block(rand_blk(), 3, 0);
    run_block(rand_blk(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
